// File: rtl/coin_input_conditioner_if.sv
// rtl/coin_input_conditioner_if.sv - button/coin-event bundle between the board buttons and the coin conditioner
interface coin_input_conditioner_if;
   logic [2:0]  btn;
   logic        accept_en;
   logic        coin_valid;
   logic [7:0]  coin_value;
   logic [2:0]  coin_onehot;
   logic        coin_reject;
   logic        jam;
   logic [15:0] total_cents;

   // Button/board side: drives raw buttons and the inhibit, observes coin events
   modport master (
      output btn,
      output accept_en,
      input  coin_valid,
      input  coin_value,
      input  coin_onehot,
      input  coin_reject,
      input  jam,
      input  total_cents
   );

   // Conditioner side
   modport slave (
      input  btn,
      input  accept_en,
      output coin_valid,
      output coin_value,
      output coin_onehot,
      output coin_reject,
      output jam,
      output total_cents
   );
endinterface

// File: rtl/coin_input_conditioner.sv
// rtl/coin_input_conditioner.sv - sync, debounce and arbitrate raw coin buttons into one-cycle coin events
module coin_input_conditioner #(
   parameter int DEBOUNCE_CYCLES = 1000000,
   parameter int CNT_W           = 20
) (
   input logic                    clk,
   input logic                    clr,
   coin_input_conditioner_if.slave bus
);

   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

   localparam logic [0:0] IDLE = 1'b0;
   localparam logic [0:0] HOLD = 1'b1;

   logic [2:0]       s1_q, s2_q;
   logic [2:0]       stable_q, stable_d;
   logic [2:0]       stable_prev_q;
   logic [CNT_W-1:0] cnt_q [3];
   logic [CNT_W-1:0] cnt_d [3];

   logic [0:0]       state_q, state_d;
   logic             coin_valid_q, coin_valid_d;
   logic [7:0]       coin_value_q, coin_value_d;
   logic [2:0]       coin_onehot_q, coin_onehot_d;
   logic             coin_reject_q, coin_reject_d;
   logic             jam_q, jam_d;
   logic [15:0]      total_q, total_d;

   logic [2:0]       rise;
   logic             multi_hot;
   logic [7:0]       press_value;

   // Two-flop synchroniser for the asynchronous buttons; s1 is never read by logic
   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         s1_q <= '0;
         s2_q <= '0;
      end else begin
         s1_q <= bus.btn;
         s2_q <= s1_q;
      end
   end

   // Per-channel debounce: a mismatch must persist DEBOUNCE_CYCLES samples before stable flips
   always_comb begin
      stable_d = stable_q;
      for (int i = 0; i < 3; i++) begin
         cnt_d[i] = '0;
         if (s2_q[i] != stable_q[i]) begin
            if (cnt_q[i] == CNT_MAX) begin
               stable_d[i] = s2_q[i];
            end else begin
               cnt_d[i] = cnt_q[i] + 1'b1;
            end
         end
      end
   end

   // Debounce state plus the delayed copy used for rising-edge detection
   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         stable_q      <= '0;
         stable_prev_q <= '0;
         for (int i = 0; i < 3; i++) begin
            cnt_q[i] <= '0;
         end
      end else begin
         stable_q      <= stable_d;
         stable_prev_q <= stable_q;
         for (int i = 0; i < 3; i++) begin
            cnt_q[i] <= cnt_d[i];
         end
      end
   end

   assign rise      = stable_q & ~stable_prev_q;
   // More than one bit set: clearing the lowest set bit leaves something behind
   assign multi_hot = |(stable_q & (stable_q - 3'd1));

   // Cents for the single held button; only meaningful when exactly one bit is set
   always_comb begin
      case (stable_q)
         3'b001:  press_value = 8'd5;
         3'b010:  press_value = 8'd10;
         3'b100:  press_value = 8'd25;
         default: press_value = 8'd0;
      endcase
   end

   // Arbiter: one decision per press in IDLE, then HOLD until every button is released
   always_comb begin
      state_d       = state_q;
      coin_valid_d  = 1'b0;
      coin_value_d  = 8'd0;
      coin_onehot_d = 3'b000;
      coin_reject_d = 1'b0;
      jam_d         = multi_hot;
      total_d       = total_q;
      case (state_q)
         IDLE: begin
            if (|rise) begin
               state_d = HOLD;
               if (multi_hot) begin
                  coin_reject_d = 1'b1;
               end else if (bus.accept_en) begin
                  coin_valid_d  = 1'b1;
                  coin_value_d  = press_value;
                  coin_onehot_d = stable_q;
                  total_d       = total_q + {8'd0, press_value};
               end else begin
                  coin_reject_d = 1'b1;
               end
            end
         end
         HOLD: begin
            if (stable_q == 3'b000) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Registered arbiter state and outputs
   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         state_q       <= IDLE;
         coin_valid_q  <= 1'b0;
         coin_value_q  <= 8'd0;
         coin_onehot_q <= 3'b000;
         coin_reject_q <= 1'b0;
         jam_q         <= 1'b0;
         total_q       <= 16'd0;
      end else begin
         state_q       <= state_d;
         coin_valid_q  <= coin_valid_d;
         coin_value_q  <= coin_value_d;
         coin_onehot_q <= coin_onehot_d;
         coin_reject_q <= coin_reject_d;
         jam_q         <= jam_d;
         total_q       <= total_d;
      end
   end

   assign bus.coin_valid  = coin_valid_q;
   assign bus.coin_value  = coin_value_q;
   assign bus.coin_onehot = coin_onehot_q;
   assign bus.coin_reject = coin_reject_q;
   assign bus.jam         = jam_q;
   assign bus.total_cents = total_q;

endmodule

// File: doc/coin_input_conditioner.md
Name: coin_input_conditioner

Overview:
Upstream stage for the vending controller. Converts the three raw push-button coin inputs (nickel, dime, quarter) into clean single-cycle coin events. Each event carries its value in cents and has passed 2-flop synchronisation, per-button debouncing, one-event-per-press gating, multi-press jam detection and an accept-inhibit. Runs on the board clock and feeds the controller's coin inputs as one-clock pulses, never as level-held buttons.

Parameters:
DEBOUNCE_CYCLES, 1000000, consecutive clocks a synchronised input must differ from its stable value before the stable value flips (10 ms at 100 MHz; 4 in simulation).
CNT_W, 20, debounce counter width; must satisfy 2^CNT_W > DEBOUNCE_CYCLES.

Ports:
clk  in  1  system clock
clr  in  1  asynchronous active-high reset
btn  in  3  raw asynchronous buttons; [0]=5c, [1]=10c, [2]=25c
accept_en  in  1  high = controller can take coins; low = presses are rejected
coin_valid  out  1  one-clock pulse per accepted coin
coin_value  out  8  cents of accepted coin (5/10/25); 0 when coin_valid low
coin_onehot  out  3  one-hot copy of accepted button, valid with coin_valid; 0 otherwise
coin_reject  out  1  one-clock pulse when a press is refused (inhibit or jam)
jam  out  1  level; high while more than one debounced button is held
total_cents  out  16  running sum of accepted coin values, wraps modulo 2^16

Behaviour:
- Reset (clr high, async): sync flops, stable values, counters and FSM go to 0 / IDLE. coin_valid=0, coin_value=0, coin_onehot=0, coin_reject=0, jam=0, total_cents=0. clr mid-debounce or mid-HOLD discards all progress; no event is emitted for a press already in flight.
- Sync: each btn bit passes through two flops (s1, s2). No logic reads s1.
- Debounce, per channel, independent:
  - If s2 != stable, cnt increments. When cnt == DEBOUNCE_CYCLES-1 on a mismatched sample, stable <= s2 and cnt <= 0.
  - If s2 == stable, cnt <= 0. Any single-cycle glitch shorter than DEBOUNCE_CYCLES restarts the count.
- Rise event: stable goes 0 to 1 (registered edge detect). Releases generate no events.
- Latency: first clock edge that samples btn high = edge 0. stable rises at edge 1+DEBOUNCE_CYCLES. coin_valid is high in the cycle after edge 2+DEBOUNCE_CYCLES.
- Arbiter FSM, states IDLE, HOLD:
  - IDLE, no rise event: outputs idle.
  - IDLE, rise event and exactly one stable bit high, accept_en=1: next cycle coin_valid=1, coin_value/coin_onehot set, total_cents += value. Go HOLD.
  - IDLE, rise event and exactly one stable bit high, accept_en=0: next cycle coin_reject=1, total_cents unchanged. Go HOLD.
  - IDLE, rise event with two or more stable bits high (including simultaneous rises): coin_reject=1, jam=1, no coin. Go HOLD.
  - HOLD: ignores all rise events, including a second button added while the first is held. jam tracks (popcount(stable) >= 2) every cycle. Returns to IDLE on the cycle all stable bits are 0.
- One event per physical press: holding a button indefinitely yields exactly one coin_valid.
- accept_en is sampled only in the IDLE cycle where the rise event is seen. A later change during HOLD has no effect.
- Outputs are registered. coin_valid and coin_reject are never high in the same cycle. Each is high for exactly one cycle per press.
- total_cents: 16-bit unsigned. 65535+5 yields 4 (wrap, no saturation, no flag).

Test Plan:
- DEBOUNCE_CYCLES=4, accept_en=1. btn[1] high from edge 0, held 20 cycles. Expect exactly one coin_valid, high in the cycle after edge 6, with coin_value=10, coin_onehot=3'b010, total_cents=10. Expect no further pulse on release.
- btn[0] pulses high 3 cycles, low 1, high 3 (bounce), then held. Expect a single coin_valid, coin_value=5, only after 4 consecutive high synchronised samples.
- btn[0] and btn[2] rise on the same edge. Expect coin_reject=1 for one cycle, jam=1 until either is released, and total_cents unchanged.
- accept_en=0, press btn[2]. Expect coin_reject pulse and no coin_valid. Then set accept_en=1, release and re-press btn[2]. Expect coin_valid with value 25.
- Preload via 2621 quarters plus one dime (total_cents=65535), then press btn[0]. Expect total_cents=4.
- Assert clr 2 cycles into a btn[1] debounce, release clr while btn[1] is still held. Expect no coin until a fresh full debounce completes: one coin_valid at edge 2+DEBOUNCE_CYCLES counted from the first edge after clr falls, with all outputs 0 during clr.
